enemy_collision_scanner: RTL and testbench
==========================================

Name: enemy_collision_scanner

Overview:
- Multi-enemy successor to the single-pair player/enemy collision check.
- On a start pulse it snapshots the player position and up to NUM_ENEMIES enemy positions, then tests one enemy per clock.
- Reports a per-enemy hit mask, any-hit flag, lowest-index hit, hit count, and the player's tile coordinates.
- Sits between the position/movement logic and the game-state controller, typically started once per frame.

Parameters:
- NUM_ENEMIES, 8, number of enemy slots scanned, 1..32
- COORD_W, 10, width of one coordinate; a position is {x, y}, 2*COORD_W bits
- SPRITE_SIZE, 16, sprite edge in pixels, power of two; also the tile size
- IDX_W, 3, width of the enemy index, equal to clog2(NUM_ENEMIES), minimum 1
- CNT_W, 4, width of hit_count, equal to clog2(NUM_ENEMIES+1)
- MARGIN, 2, hitbox shrink in pixels; used only with COLLIDE_MARGIN_EN

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, scan request, sampled only in IDLE
- player_pos, input, 2*COORD_W, x in [2*COORD_W-1:COORD_W], y in [COORD_W-1:0]
- enemy_pos, input, NUM_ENEMIES*2*COORD_W, enemy k at bits [(k+1)*2*COORD_W-1 : k*2*COORD_W], same x/y packing
- enemy_valid, input, NUM_ENEMIES, 1 = slot k is live
- busy, output, 1, high from the start edge until done
- done, output, 1, one-cycle pulse when results are valid
- hit_mask, output, NUM_ENEMIES, bit k = enemy k collides
- any_hit, output, 1, OR of hit_mask
- first_hit_idx, output, IDX_W, lowest k with hit; 0 when no hit
- hit_count, output, CNT_W, number of set bits in hit_mask
- pblockposx, output, COORD_W-log2(SPRITE_SIZE), player x / SPRITE_SIZE
- pblockposy, output, COORD_W-log2(SPRITE_SIZE), player y / SPRITE_SIZE

Behaviour:
- Reset (rst_n low, async): state IDLE; busy, done, hit_mask, any_hit, first_hit_idx, hit_count, pblockposx/y, idx and all snapshot registers are 0. Reset mid-scan aborts the scan immediately, with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On a clock edge with start=1, capture player_pos, enemy_pos and enemy_valid into shadow registers.
  - Load pblockposx/y from the captured player_pos. Division is a right shift by log2(SPRITE_SIZE).
  - Clear hit_mask, any_hit, first_hit_idx and hit_count; set idx=0 and busy=1; go to SCAN.
- SCAN:
  - Each cycle evaluate shadow enemy idx.
  - Hit rule: valid[idx] && |ex-px| <= THR && |ey-py| <= THR, with THR = SPRITE_SIZE. Edges touching count as a hit.
  - Absolute difference is computed in COORD_W+1 bits. There is no wrap-around, so px=1020, ex=4 is not a hit.
  - On a hit: set hit_mask[idx] and any_hit, and increment hit_count. If this is the first hit of the scan, load first_hit_idx=idx.
  - When idx==NUM_ENEMIES-1, go to DONE; otherwise idx+1.
- DONE: done=1 for exactly this cycle, busy=0 on exit, return to IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge NUM_ENEMIES+1. With the defaults that is 9 cycles from start to done.
- Result outputs hold their values from DONE until the next accepted start, which clears them.
- start while busy (SCAN or DONE) is ignored and not queued.
- start held high continuously produces back-to-back scans, one per NUM_ENEMIES+2 cycles.
- Input changes during a scan have no effect; only the snapshot is used.
- enemy_valid=0 for a slot forces its mask bit to 0 regardless of position.
- NUM_ENEMIES=1 is legal: a single SCAN cycle.

Optional Feature:
- Macro: COLLIDE_MARGIN_EN.
- Defined: THR = SPRITE_SIZE - MARGIN, giving a forgiving shrunken hitbox. MARGIN must be less than SPRITE_SIZE.
- Not defined: THR = SPRITE_SIZE, MARGIN is unused, and behaviour is exactly as above.

Test Plan:
- Reset then idle: rst_n low for 3 cycles then high, no start -> all outputs 0, busy 0, no done pulse.
- Single right/down hit: player (100,100); enemy0 (116,116) valid, others invalid; start 1 cycle -> done 9 cycles later; hit_mask=8'h01, any_hit=1, first_hit_idx=0, hit_count=1, pblockposx=6, pblockposy=6.
- Left/up, miss and invalid:
  - player (200,50); enemy3 (184,34); enemy5 (183,50); enemy6 (200,50) with valid[6]=0.
  - Expect hit_mask=8'h08, first_hit_idx=3, hit_count=1.
- Multiple hits and no wrap:
  - player (1020,5); enemies 2,4,7 at (1010,0), (1020,21), (1004,12); enemy1 at (4,5).
  - Expect hit_mask=8'h94, first_hit_idx=2, hit_count=3.
- Start during busy and mid-scan reset:
  - Pulse start again at cycle 3 of a scan -> ignored; a single done pulse at cycle 9.
  - New scan; assert rst_n low at cycle 4 -> outputs 0 immediately, no done.
- COLLIDE_MARGIN_EN defined, MARGIN=2: player (100,100); enemy0 (114,100), enemy1 (115,100) -> hit_mask=8'h01. Without the macro -> 8'h03.

Source files
------------

// File: rtl/enemy_collision_scanner.sv
// Snapshots the player and NUM_ENEMIES enemy positions on start, then tests one enemy per clock
// for sprite overlap. Optional macro COLLIDE_MARGIN_EN shrinks the hitbox by MARGIN pixels.
module enemy_collision_scanner #(
    parameter int NUM_ENEMIES = 8,
    parameter int COORD_W     = 10,
    parameter int SPRITE_SIZE = 16,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 4,
    parameter int MARGIN      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [2*COORD_W-1:0]                 player_pos,
    input  logic [NUM_ENEMIES*2*COORD_W-1:0]     enemy_pos,
    input  logic [NUM_ENEMIES-1:0]               enemy_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [NUM_ENEMIES-1:0]               hit_mask,
    output logic                                 any_hit,
    output logic [IDX_W-1:0]                     first_hit_idx,
    output logic [CNT_W-1:0]                     hit_count,
    output logic [COORD_W-$clog2(SPRITE_SIZE)-1:0] pblockposx,
    output logic [COORD_W-$clog2(SPRITE_SIZE)-1:0] pblockposy
);
    localparam int SHIFT = $clog2(SPRITE_SIZE);
    localparam int PW    = 2 * COORD_W;

`ifdef COLLIDE_MARGIN_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif
    localparam int THR = MARGIN_ON ? SPRITE_SIZE - MARGIN : SPRITE_SIZE;
    localparam logic [COORD_W:0] THR_V = (COORD_W + 1)'(THR);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic [PW-1:0]          snap_player;
    logic [PW-1:0]          snap_enemy [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] snap_valid;

    logic                   last;
    logic [COORD_W-1:0]     px, py, ex, ey;
    logic [COORD_W:0]       dx, dy;
    logic                   hit;

    assign last = (idx == IDX_W'(NUM_ENEMIES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Differences are one bit wider than a coordinate so the screen never wraps.
    always_comb begin
        px  = snap_player[PW-1:COORD_W];
        py  = snap_player[COORD_W-1:0];
        ex  = snap_enemy[idx][PW-1:COORD_W];
        ey  = snap_enemy[idx][COORD_W-1:0];
        dx  = (ex >= px) ? ({1'b0, ex} - {1'b0, px}) : ({1'b0, px} - {1'b0, ex});
        dy  = (ey >= py) ? ({1'b0, ey} - {1'b0, py}) : ({1'b0, py} - {1'b0, ey});
        hit = snap_valid[idx] && (dx <= THR_V) && (dy <= THR_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            hit_mask      <= '0;
            any_hit       <= 1'b0;
            first_hit_idx <= '0;
            hit_count     <= '0;
            pblockposx    <= '0;
            pblockposy    <= '0;
            idx           <= '0;
            snap_player   <= '0;
            snap_valid    <= '0;
            for (int k = 0; k < NUM_ENEMIES; k++) snap_enemy[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap_player   <= player_pos;
                        snap_valid    <= enemy_valid;
                        for (int k = 0; k < NUM_ENEMIES; k++)
                            snap_enemy[k] <= enemy_pos[k*PW +: PW];
                        pblockposx    <= player_pos[PW-1:COORD_W+SHIFT];
                        pblockposy    <= player_pos[COORD_W-1:SHIFT];
                        hit_mask      <= '0;
                        any_hit       <= 1'b0;
                        first_hit_idx <= '0;
                        hit_count     <= '0;
                        idx           <= '0;
                        busy          <= 1'b1;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        hit_mask[idx] <= 1'b1;
                        any_hit       <= 1'b1;
                        hit_count     <= hit_count + CNT_W'(1);
                        if (!any_hit) first_hit_idx <= idx;
                    end
                    if (!last) idx <= idx + IDX_W'(1);
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_collision_scanner.sv
// Bench for enemy_collision_scanner: behavioural scan model checked every cycle, plus literal
// expectations for the hand-worked scenarios.
`timescale 1ns/1ps
module tb_enemy_collision_scanner;
    localparam int N    = 8;
    localparam int CW   = 10;
    localparam int SS   = 16;
    localparam int IW   = 3;
    localparam int CNTW = 4;
    localparam int MG   = 2;
    localparam int BW   = CW - $clog2(SS);
`ifdef COLLIDE_MARGIN_EN
    localparam int THR = SS - MG;
`else
    localparam int THR = SS;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [2*CW-1:0]   player_pos = '0;
    logic [N*2*CW-1:0] enemy_pos = '0;
    logic [N-1:0]      enemy_valid = '0;
    logic              busy, done, any_hit;
    logic [N-1:0]      hit_mask;
    logic [IW-1:0]     first_hit_idx;
    logic [CNTW-1:0]   hit_count;
    logic [BW-1:0]     pblockposx, pblockposy;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    enemy_collision_scanner #(
        .NUM_ENEMIES(N), .COORD_W(CW), .SPRITE_SIZE(SS),
        .IDX_W(IW), .CNT_W(CNTW), .MARGIN(MG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .player_pos(player_pos), .enemy_pos(enemy_pos), .enemy_valid(enemy_valid),
        .busy(busy), .done(done), .hit_mask(hit_mask), .any_hit(any_hit),
        .first_hit_idx(first_hit_idx), .hit_count(hit_count),
        .pblockposx(pblockposx), .pblockposy(pblockposy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts clock edges since the accepted start; -1 = never started.
    int           m_age = -1;
    logic [N-1:0] m_mask = '0, p_mask;
    int           m_cnt = 0, m_first = 0, p_cnt, p_first;
    int           m_bx = 0, m_by = 0;

    function automatic void ref_scan(output logic [N-1:0] mask, output int cnt, output int first);
        int px, py, ex, ey, adx, ady;
        mask  = '0;
        cnt   = 0;
        first = -1;
        px = int'(player_pos[2*CW-1:CW]);
        py = int'(player_pos[CW-1:0]);
        for (int k = 0; k < N; k++) begin
            ex  = int'(enemy_pos[k*2*CW+CW +: CW]);
            ey  = int'(enemy_pos[k*2*CW +: CW]);
            adx = (ex > px) ? ex - px : px - ex;
            ady = (ey > py) ? ey - py : py - ey;
            if (enemy_valid[k] && adx <= THR && ady <= THR) begin
                mask[k] = 1'b1;
                cnt++;
                if (first < 0) first = k;
            end
        end
        if (first < 0) first = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = -1; m_mask = '0; m_cnt = 0; m_first = 0; m_bx = 0; m_by = 0;
        end else if (m_age < 0 || m_age >= N + 1) begin
            if (start) begin
                ref_scan(p_mask, p_cnt, p_first);
                m_mask = '0; m_cnt = 0; m_first = 0;
                m_bx = int'(player_pos[2*CW-1:CW]) / SS;
                m_by = int'(player_pos[CW-1:0]) / SS;
                m_age = 0;
            end else if (m_age == N + 1) begin
                m_age = N + 2;
            end
        end else begin
            m_age++;
            if (m_age == N + 1) begin
                m_mask = p_mask; m_cnt = p_cnt; m_first = p_first;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_age >= 0 && m_age <= N));
            chk("done", 32'(done), 32'(m_age == N + 1));
            if (!(m_age >= 0 && m_age <= N)) begin
                chk("hit_mask", 32'(hit_mask), 32'(m_mask));
                chk("any_hit", 32'(any_hit), 32'(m_mask != 0));
                chk("first_hit_idx", 32'(first_hit_idx), 32'(m_first));
                chk("hit_count", 32'(hit_count), 32'(m_cnt));
                chk("pblockposx", 32'(pblockposx), 32'(m_bx));
                chk("pblockposy", 32'(pblockposy), 32'(m_by));
            end
        end
    end

    always @(negedge clk) if (done) done_seen++;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        enemy_pos   = '0;
        enemy_valid = '0;
    endtask

    task automatic set_player(input int x, input int y);
        player_pos = {CW'(x), CW'(y)};
    endtask

    task automatic set_enemy(input int k, input int x, input int y, input bit v);
        enemy_pos[k*2*CW +: 2*CW] = {CW'(x), CW'(y)};
        enemy_valid[k] = v;
    endtask

    // Call just after a falling edge; start is seen on the next rising edge only.
    task automatic fire();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk(name, 32'(lat), 32'(exp_lat));
    endtask

    task automatic scramble();
        player_pos  = 20'($urandom);
        enemy_pos   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        enemy_valid = N'($urandom);
    endtask

    int ds0;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset then idle
        @(negedge clk); chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_done", 32'(done_seen), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // single right/down hit, edges touching
        #1 clear_inputs(); set_player(100, 100); set_enemy(0, 116, 116, 1'b1);
        fire(); wait_done("t1_latency", N + 1);
        chk("t1_mask", 32'(hit_mask), 32'h01);
        chk("t1_model_mask", 32'(m_mask), 32'h01);
        chk("t1_any", 32'(any_hit), 32'd1);
        chk("t1_first", 32'(first_hit_idx), 32'd0);
        chk("t1_count", 32'(hit_count), 32'd1);
        chk("t1_bx", 32'(pblockposx), 32'd6);
        chk("t1_by", 32'(pblockposy), 32'd6);

        // left/up hit, one-pixel miss, invalid slot on top of player
        @(negedge clk); #1 clear_inputs(); set_player(200, 50);
        set_enemy(3, 184, 34, 1'b1); set_enemy(5, 183, 50, 1'b1); set_enemy(6, 200, 50, 1'b0);
        fire(); wait_done("t2_latency", N + 1);
        chk("t2_mask", 32'(hit_mask), 32'h08);
        chk("t2_first", 32'(first_hit_idx), 32'd3);
        chk("t2_count", 32'(hit_count), 32'd1);

        // multiple hits, no wrap across the screen edge
        @(negedge clk); #1 clear_inputs(); set_player(1020, 5);
        set_enemy(2, 1010, 0, 1'b1); set_enemy(4, 1020, 21, 1'b1);
        set_enemy(7, 1004, 12, 1'b1); set_enemy(1, 4, 5, 1'b1);
        fire(); wait_done("t3_latency", N + 1);
        chk("t3_mask", 32'(hit_mask), 32'h94);
        chk("t3_model_mask", 32'(m_mask), 32'h94);
        chk("t3_first", 32'(first_hit_idx), 32'd2);
        chk("t3_count", 32'(hit_count), 32'd3);
        chk("t3_bx", 32'(pblockposx), 32'd63);

        // hitbox threshold
        @(negedge clk); #1 clear_inputs(); set_player(100, 100);
        set_enemy(0, 114, 100, 1'b1); set_enemy(1, 115, 100, 1'b1);
        fire(); wait_done("t4_latency", N + 1);
`ifdef COLLIDE_MARGIN_EN
        chk("t4_mask", 32'(hit_mask), 32'h01);
`else
        chk("t4_mask", 32'(hit_mask), 32'h03);
`endif

        // start while busy is ignored
        @(negedge clk); #1 ds0 = done_seen;
        fire();
        repeat (2) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("busy_start_dones", 32'(done_seen - ds0), 32'd1);

        // reset in the middle of a scan
        #1 clear_inputs(); set_player(1020, 5);
        set_enemy(2, 1010, 0, 1'b1); set_enemy(4, 1020, 21, 1'b1);
        ds0 = done_seen;
        fire();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mask", 32'(hit_mask), 32'd0);
        chk("rst_bx", 32'(pblockposx), 32'd0);
        chk("rst_count", 32'(hit_count), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_no_done", 32'(done_seen - ds0), 32'd0);

        // start held high: one scan per N+2 cycles
        #1 ds0 = done_seen; start = 1'b1;
        repeat (3 * (N + 2)) @(negedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("b2b_dones", 32'(done_seen - ds0), 32'd3);

        // randomized scans with input churn during the scan
        for (int t = 0; t < 80; t++) begin
            int px, py;
            #1;
            px = $urandom_range(20, 1000);
            py = $urandom_range(20, 1000);
            set_player(px, py);
            for (int k = 0; k < N; k++)
                set_enemy(k, px + $urandom_range(0, 40) - 20, py + $urandom_range(0, 40) - 20,
                          1'($urandom_range(0, 3) != 0));
            fire();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); #1;
                scramble();
                start = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            wait_done("rand_latency", N - 3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
